// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
//   Rectangle-fill engine placed in front of the vga_pixel framebuffer. The CPU
//   programs a rectangle (X0, Y0, W, H) and an 8-bit grey level over an
//   Avalon-MM slave. On start, the engine clips the rectangle to the
//   framebuffer and emits one framebuffer write per pixel, row-major, with
//   valid/ready backpressure. Completion sets a sticky done flag and can raise
//   a level interrupt.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   avs_*             register slave (1-cycle read latency on avs_readdata)
//                       0 X0, 1 Y0, 2 W, 3 H, 4 COLOR[7:0]
//                       5 CTRL   bit0 start (pulse, reads 0), bit1 irq_en
//                       6 STATUS bit0 busy (RO), bit1 done (sticky, W1C)
//                       7 COUNT  pixels accepted in current/last fill
//   fb_address_o-ish  fb_address / fb_writedata / fb_write: pixel write port
//   fb_ready          framebuffer accepts the write this cycle
//   irq               done & irq_en
//   dbg_state         current FSM state (IDLE=0, SETUP=1, FILL=2, DONE=3)
//
// Handshake: a pixel transfers on any clk edge where fb_write && fb_ready.
// While fb_write is high and fb_ready is low, fb_address and fb_writedata are
// held unchanged; fb_write never drops until the pixel is accepted.
// -----------------------------------------------------------------------------
module fb_rect_fill #(
  parameter int FB_W = 640,
  parameter int FB_H = 480,
  parameter int AW   = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          avs_chipselect,
  input  logic [2:0]    avs_address,
  input  logic          avs_write,
  input  logic [15:0]   avs_writedata,
  input  logic          avs_read,
  output logic [15:0]   avs_readdata,
  output logic [AW-1:0] fb_address,
  output logic [7:0]    fb_writedata,
  output logic          fb_write,
  input  logic          fb_ready,
  output logic          irq,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [16:0]   FB_W_17 = 17'(FB_W);
  localparam logic [16:0]   FB_H_17 = 17'(FB_H);
  localparam logic [AW-1:0] FB_W_A  = AW'(FB_W);

  state_t          state_q, state_d;
  logic [15:0]     x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [7:0]      color_q, color_d;
  logic            irq_en_q, irq_en_d;
  logic            done_q, done_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     rd_q, rd_d;

  // Fill geometry, frozen at SETUP so register writes during a fill are harmless.
  logic [15:0]     x_start_q, x_start_d;
  logic [15:0]     x_last_q, x_last_d;
  logic [15:0]     y_last_q, y_last_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic [AW-1:0]   row_base_q, row_base_d;

  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            wr_q, wr_d;

  logic            reg_wr;
  logic            start_req;
  logic            done_set;
  logic            rect_empty;
  logic [16:0]     xe_sum, ye_sum, xe_clip, ye_clip;
  logic [AW-1:0]   row_base_init;
  logic [15:0]     rd_mux;

  assign reg_wr    = avs_chipselect && avs_write;
  assign start_req = reg_wr && (avs_address == 3'd5) && avs_writedata[0]
                     && (state_q == S_IDLE);

  // Clipping: 17-bit sums so X0+W cannot wrap before the compare.
  always_comb begin
    xe_sum        = {1'b0, x0_q} + {1'b0, w_q};
    ye_sum        = {1'b0, y0_q} + {1'b0, h_q};
    xe_clip       = (xe_sum > FB_W_17) ? FB_W_17 : xe_sum;
    ye_clip       = (ye_sum > FB_H_17) ? FB_H_17 : ye_sum;
    rect_empty    = (w_q == 16'd0) || (h_q == 16'd0) ||
                    ({1'b0, x0_q} >= FB_W_17) || ({1'b0, y0_q} >= FB_H_17);
    // The only multiply; FILL steps rows by adding FB_W.
    row_base_init = AW'(y0_q) * FB_W_A;
  end

  always_comb begin
    rd_mux = 16'd0;
    case (avs_address)
      3'd0: rd_mux = x0_q;
      3'd1: rd_mux = y0_q;
      3'd2: rd_mux = w_q;
      3'd3: rd_mux = h_q;
      3'd4: rd_mux = {8'd0, color_q};
      3'd5: rd_mux = {14'd0, irq_en_q, 1'b0};
      3'd6: rd_mux = {14'd0, done_q, (state_q != S_IDLE)};
      3'd7: rd_mux = count_q;
      default: rd_mux = 16'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    count_d    = count_q;
    rd_d       = 16'd0;
    x_start_d  = x_start_q;
    x_last_d   = x_last_q;
    y_last_d   = y_last_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    done_set   = 1'b0;

    if (avs_chipselect && avs_read) begin
      rd_d = rd_mux;
    end

    if (reg_wr) begin
      case (avs_address)
        3'd0: x0_d     = avs_writedata;
        3'd1: y0_d     = avs_writedata;
        3'd2: w_d      = avs_writedata;
        3'd3: h_d      = avs_writedata;
        3'd4: color_d  = avs_writedata[7:0];
        3'd5: irq_en_d = avs_writedata[1];
        3'd6: if (avs_writedata[1]) done_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_SETUP;
          count_d = 16'd0;
          done_d  = 1'b0;
        end
      end
      S_SETUP: begin
        wdata_d   = color_q;
        x_start_d = x0_q;
        x_last_d  = 16'(xe_clip - 17'd1);
        y_last_d  = 16'(ye_clip - 17'd1);
        if (rect_empty) begin
          state_d  = S_DONE;
          done_set = 1'b1;
        end else begin
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = row_base_init;
          addr_d     = row_base_init + AW'(x0_q);
          wr_d       = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (fb_ready) begin
          count_d = count_q + 16'd1;
          if (x_q == x_last_q) begin
            if (y_q == y_last_q) begin
              wr_d     = 1'b0;
              state_d  = S_DONE;
              done_set = 1'b1;
            end else begin
              x_d        = x_start_q;
              y_d        = y_q + 16'd1;
              row_base_d = row_base_q + FB_W_A;
              addr_d     = row_base_q + FB_W_A + AW'(x_start_q);
            end
          end else begin
            x_d    = x_q + 16'd1;
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion wins over a simultaneous W1C write.
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      x_start_q  <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      x_start_q  <= x_start_d;
      x_last_q   <= x_last_d;
      y_last_q   <= y_last_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
    end
  end

  assign avs_readdata = rd_q;
  assign fb_address   = addr_q;
  assign fb_writedata = wdata_q;
  assign fb_write     = wr_q;
  assign irq          = done_q & irq_en_q;
  assign dbg_state    = state_q;

endmodule
